req_ack_responder: RTL and testbench
====================================

// Module: req_ack_responder
// PURPOSE
//  Target-side end of the single-bit req/ack handshake used by the req/ack generator.
//  - Detects each req rising edge and answers with a 1-cycle ack pulse after a
//    programmable latency.
//  - Queues up to MAX_PEND outstanding requests.
//  - Flags overflow and supports backpressure (stall).
//  - Serves as the responder model in SVA test benches.
// PARAMETERS
//  ACK_DELAY  1   cycles from req-sampled cycle to ack cycle; legal >=1
//  MAX_PEND   4   max accepted-but-unacked requests, incl. the one in service; >=1
//  CNT_W      16  width of txn_count
// PORTS
//  clk           in   1           single clock, all logic on posedge
//  reset_n       in   1           synchronous, active-low reset
//  req           in   1           request from initiator; rising edge = 1 request
//  stall         in   1           1 = hold off ack issue
//  ack           out  1           1-cycle acknowledge pulse, registered
//  busy          out  1           1 when pend_cnt != 0
//  pend_cnt      out  $clog2(MAX_PEND+1)  outstanding requests
//  overflow_err  out  1           1-cycle pulse: request dropped
//  txn_count     out  CNT_W       acks issued, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge):
//    - ack=0, busy=0, pend_cnt=0, overflow_err=0, txn_count=0.
//    - FSM=IDLE, delay counter=0, req_q=0.
//    - Reset mid-operation discards all pending requests; no ack is issued for them.
//  - Edge detect:
//    - req_q <= req each cycle; new_req = req & ~req_q.
//    - req held high across reset release counts as one new request.
//  - Accept:
//    - new_req with pend_cnt < MAX_PEND: pend_cnt +1.
//    - new_req with pend_cnt == MAX_PEND and no ack this cycle: request dropped,
//      overflow_err=1 next cycle.
//    - new_req and ack in the same cycle: pend_cnt unchanged; never overflows.
//  - FSM states: IDLE, WAIT, ACK.
//    - IDLE -> WAIT: on new_req or pend_cnt>0; delay counter loaded.
//      This cycle is the service start S.
//    - WAIT: counts; ack is high in cycle S+ACK_DELAY, or the first later cycle
//      with stall=0.
//    - ACK (1 cycle, ack=1): pend_cnt -1, txn_count +1.
//      - -> WAIT if pend_cnt after decrement >0; the cycle after ACK is the new S.
//      - -> IDLE otherwise.
//    - ACK_DELAY=1: idle responder, req rises in cycle N -> ack in cycle N+1.
//  - Stall:
//    - Only delays the ack cycle; does not block accept.
//    - stall deasserting allows ack in that same cycle.
//  - ack is never high two consecutive cycles.
//  - Arithmetic:
//    - pend_cnt saturates at MAX_PEND, never underflows.
//    - txn_count wraps 2^CNT_W-1 -> 0.
//  - req falling edges and req level are otherwise ignored.
// CONFIGURATION
//  - REQ_ACK_RESP_COUNT_EN defined: txn_count is implemented as above.
//  - REQ_ACK_RESP_COUNT_EN undefined:
//    - No counter logic is built; txn_count is tied to 0.
//    - All other behaviour is identical.
// TESTING
//  1 Reset, ACK_DELAY=1; req=1 cycle 5 only -> ack=1 cycle 6 only;
//    pend_cnt 1 in cycles 6, 0 from 7; txn_count=1.
//  2 ACK_DELAY=3, req pulses cycles 10 and 12 -> acks cycles 13 and 17;
//    pend_cnt max 2; busy low from cycle 18.
//  3 MAX_PEND=4, ACK_DELAY=8, 5 req pulses every 2 cycles -> 5th dropped;
//    overflow_err 1 cycle; exactly 4 acks.
//  4 ACK_DELAY=1, stall=1 cycles 20-24, req cycle 20 -> ack cycle 25; no overflow.
//  5 Reset asserted with pend_cnt=3 mid-WAIT -> all outputs 0 next cycle;
//    no ack until a new req edge.
//  6 CNT_W=4, 17 transactions with macro defined -> txn_count=1;
//    macro undefined -> txn_count=0 throughout.

Source files
------------

// File: rtl/req_ack_responder.sv
// Target-side responder for the single-bit req/ack handshake: one registered ack pulse
// per req rising edge after ACK_DELAY cycles. Define REQ_ACK_RESP_COUNT_EN to build txn_count.
module req_ack_responder #(
    parameter int ACK_DELAY = 1,
    parameter int MAX_PEND  = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req,
    input  logic                           stall,
    output logic                           ack,
    output logic                           busy,
    output logic [$clog2(MAX_PEND+1)-1:0]  pend_cnt,
    output logic                           overflow_err,
    output logic [CNT_W-1:0]               txn_count
);

    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int DW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
    localparam logic [DW-1:0] DLY_LOAD = DW'(ACK_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // Handshake: each req rising edge is one request; ack is a single-cycle pulse
    // and is never high in two consecutive cycles.
    state_t          state_q, state_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic            req_q;
    logic            ack_q;
    logic            ovf_q;
    logic            new_req;
    logic            ack_cycle;
    logic            accept;
    logic            drop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            pend_q  <= '0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            pend_q  <= pend_d;
            req_q   <= req;
            ack_q   <= (state_d == S_ACK);
            ovf_q   <= drop;
        end
    end

    always_comb begin
        new_req   = req & ~req_q;
        ack_cycle = (state_q == S_ACK);
        // A request arriving while the ack retires a slot always finds room.
        accept    = new_req && ((pend_q != PEND_MAX) || ack_cycle);
        drop      = new_req && !accept;

        pend_d = pend_q;
        if (accept && !ack_cycle) begin
            pend_d = pend_q + PW'(1);
        end else if (!accept && ack_cycle && (pend_q != '0)) begin
            pend_d = pend_q - PW'(1);
        end

        state_d = state_q;
        dly_d   = dly_q;
        case (state_q)
            S_IDLE: begin
                if (new_req || (pend_q != '0)) begin
                    state_d = S_WAIT;
                    dly_d   = DLY_LOAD;
                end
            end
            S_WAIT: begin
                if (dly_q == '0) begin
                    if (!stall) begin
                        state_d = S_ACK;
                    end
                end else begin
                    dly_d = dly_q - DW'(1);
                end
            end
            S_ACK: begin
                if (pend_d != '0) begin
                    state_d = S_WAIT;
                    dly_d   = DLY_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                dly_d   = '0;
            end
        endcase
    end

    assign ack          = ack_q;
    assign busy         = (pend_q != '0);
    assign pend_cnt     = pend_q;
    assign overflow_err = ovf_q;

`ifdef REQ_ACK_RESP_COUNT_EN
    logic [CNT_W-1:0] txn_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            txn_q <= '0;
        end else if (ack_cycle) begin
            txn_q <= txn_q + CNT_W'(1);
        end
    end

    assign txn_count = txn_q;
`else
    assign txn_count = '0;
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder: three instances (ACK_DELAY 1/3/8) sharing clock and reset,
// checked cycle by cycle against hand-computed values.
module tb_req_ack_responder;

    logic clk = 1'b0;
    logic reset_n;
    logic req1, stall1, req3, stall3, req8, stall8;

    logic        ack1, busy1, ovf1;
    logic [2:0]  pend1;
    logic [3:0]  txn1;
    logic        ack3, busy3, ovf3;
    logic [2:0]  pend3;
    logic [15:0] txn3;
    logic        ack8, busy8, ovf8;
    logic [2:0]  pend8;
    logic [15:0] txn8;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    req_ack_responder #(.ACK_DELAY(1), .MAX_PEND(4), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req1), .stall(stall1),
        .ack(ack1), .busy(busy1), .pend_cnt(pend1), .overflow_err(ovf1), .txn_count(txn1)
    );

    req_ack_responder #(.ACK_DELAY(3), .MAX_PEND(4), .CNT_W(16)) dut3 (
        .clk(clk), .reset_n(reset_n), .req(req3), .stall(stall3),
        .ack(ack3), .busy(busy3), .pend_cnt(pend3), .overflow_err(ovf3), .txn_count(txn3)
    );

    req_ack_responder #(.ACK_DELAY(8), .MAX_PEND(4), .CNT_W(16)) dut8 (
        .clk(clk), .reset_n(reset_n), .req(req8), .stall(stall8),
        .ack(ack8), .busy(busy8), .pend_cnt(pend8), .overflow_err(ovf8), .txn_count(txn8)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_txn(input int n, input int w);
`ifdef REQ_ACK_RESP_COUNT_EN
        return 32'(n % (1 << w));
`else
        return 32'(0 * n * w);
`endif
    endfunction

    // ACK_DELAY=3, pulses at relative cycles 0 and 2
    int t2_req [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    int t2_ack [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int t2_pend[9] = '{1, 1, 2, 2, 1, 1, 1, 1, 0};

    initial begin
        int n_ack;
        int n_ovf;
        int max_pend;

        reset_n = 1'b0;
        req1 = 1'b0; stall1 = 1'b0;
        req3 = 1'b0; stall3 = 1'b0;
        req8 = 1'b0; stall8 = 1'b0;
        tick();
        tick();
        check_eq("rst_ack",  32'(ack1),  0);
        check_eq("rst_busy", 32'(busy1), 0);
        check_eq("rst_pend", 32'(pend1), 0);
        check_eq("rst_ovf",  32'(ovf1),  0);
        check_eq("rst_txn",  32'(txn1),  0);
        reset_n = 1'b1;
        tick();
        tick();

        // single request, ACK_DELAY=1
        req1 = 1'b1; tick();
        check_eq("t1_pend_req", 32'(pend1), 1);
        check_eq("t1_ack_req",  32'(ack1),  0);
        req1 = 1'b0; tick();
        check_eq("t1_ack",      32'(ack1),  1);
        check_eq("t1_pend_ack", 32'(pend1), 1);
        tick();
        check_eq("t1_ack_off",  32'(ack1),  0);
        check_eq("t1_pend_end", 32'(pend1), 0);
        check_eq("t1_busy_end", 32'(busy1), 0);
        check_eq("t1_txn",      txn1,       exp_txn(1, 4));

        // stall holds the ack but not the accept
        stall1 = 1'b1; req1 = 1'b1; tick();
        check_eq("t4_pend", 32'(pend1), 1);
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t4_stalled_ack", 32'(ack1), 0);
        end
        stall1 = 1'b0; tick();
        check_eq("t4_ack",     32'(ack1),  1);
        tick();
        check_eq("t4_ack_off", 32'(ack1),  0);
        check_eq("t4_pend",    32'(pend1), 0);
        check_eq("t4_ovf",     32'(ovf1),  0);
        check_eq("t4_txn",     txn1,       exp_txn(2, 4));

        // new request coincident with ack: count holds, ack not repeated next cycle
        req1 = 1'b1; tick();
        req1 = 1'b0; tick();
        check_eq("bb_ack1", 32'(ack1), 1);
        req1 = 1'b1; tick();
        check_eq("bb_gap_ack",  32'(ack1),  0);
        check_eq("bb_gap_pend", 32'(pend1), 1);
        check_eq("bb_gap_ovf",  32'(ovf1),  0);
        req1 = 1'b0; tick();
        check_eq("bb_ack2", 32'(ack1), 1);
        tick();
        check_eq("bb_pend_end", 32'(pend1), 0);
        check_eq("bb_txn",      txn1,       exp_txn(4, 4));

        // two queued requests, ACK_DELAY=3
        for (int i = 0; i < 9; i++) begin
            req3 = t2_req[i][0];
            tick();
            check_eq("t2_ack",  32'(ack3),  32'(t2_ack[i]));
            check_eq("t2_pend", 32'(pend3), 32'(t2_pend[i]));
            check_eq("t2_busy", 32'(busy3), 32'(t2_pend[i] != 0));
        end
        check_eq("t2_txn", txn3, exp_txn(2, 16));

        // overflow: five pulses into a 4-deep queue, ACK_DELAY=8
        exp_q = {};
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd17);
        exp_q.push_back(32'd26);
        exp_q.push_back(32'd35);
        n_ack = 0; n_ovf = 0; max_pend = 0;
        for (int i = 0; i < 41; i++) begin
            req8 = (i <= 8) && (i % 2 == 0);
            tick();
            if (ack8) begin
                n_ack = n_ack + 1;
                if (exp_q.size() == 0) check_eq("t3_extra_ack", 32'(ack8), 0);
                else check_eq("t3_ack_cycle", 32'(i), exp_q.pop_front());
            end
            if (ovf8) n_ovf = n_ovf + 1;
            if (int'(pend8) > max_pend) max_pend = int'(pend8);
            if (i == 8) begin
                check_eq("t3_ovf_pulse", 32'(ovf8),  1);
                check_eq("t3_pend_full", 32'(pend8), 4);
            end
            if (i == 9) check_eq("t3_ovf_clear", 32'(ovf8), 0);
        end
        req8 = 1'b0;
        check_eq("t3_n_ack",    32'(n_ack),        4);
        check_eq("t3_n_ovf",    32'(n_ovf),        1);
        check_eq("t3_max_pend", 32'(max_pend),     4);
        check_eq("t3_sb_left",  32'(exp_q.size()), 0);
        check_eq("t3_pend_end", 32'(pend8),        0);
        check_eq("t3_txn",      txn8,              exp_txn(4, 16));

        // reset mid-WAIT with three pending; dut1 sees req held across reset release
        for (int i = 0; i < 6; i++) begin
            req8 = (i <= 4) && (i % 2 == 0);
            tick();
        end
        req8 = 1'b0;
        check_eq("t5_pend_pre", 32'(pend8), 3);
        check_eq("t5_ack_pre",  32'(ack8),  0);
        reset_n = 1'b0; req1 = 1'b1; tick();
        check_eq("t5_ack",  32'(ack8),  0);
        check_eq("t5_busy", 32'(busy8), 0);
        check_eq("t5_pend", 32'(pend8), 0);
        check_eq("t5_ovf",  32'(ovf8),  0);
        check_eq("t5_txn",  32'(txn8),  0);
        reset_n = 1'b1; tick();
        check_eq("t5_held_req_pend", 32'(pend1), 1);
        req1 = 1'b0; tick();
        check_eq("t5_held_req_ack", 32'(ack1), 1);
        n_ack = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack8) n_ack = n_ack + 1;
        end
        check_eq("t5_no_ack",   32'(n_ack), 0);
        check_eq("t5_pend_end", 32'(pend8), 0);
        check_eq("t5_txn1",     txn1,       exp_txn(1, 4));

        // txn_count wrap on the 4-bit instance
        for (int k = 2; k <= 17; k++) begin
            req1 = 1'b1; tick();
            req1 = 1'b0; tick();
            check_eq("t6_ack", 32'(ack1), 1);
            tick();
            if (k == 15) check_eq("t6_txn_15", txn1, exp_txn(15, 4));
            if (k == 16) check_eq("t6_txn_16", txn1, exp_txn(16, 4));
        end
        check_eq("t6_txn_17", txn1, exp_txn(17, 4));
        check_eq("t6_pend",   32'(pend1), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
